// File: rtl/ones_count_accumulator_pkg.sv
// Shared types and helpers for the frame-level ones-count accumulator.
package ones_count_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int DEFAULT_FRAME_LEN = 8;

    // Bits needed to hold a frame total of up to 3*n.
    function automatic int cnt_width(input int n);
        return $clog2(3 * n + 1);
    endfunction

endpackage

// File: rtl/ones_count_accumulator_group_counter.sv
// Modulo-FRAME_LEN group counter; last flags the enable cycle that accepts the final group.
module group_counter #(
    parameter int FRAME_LEN = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic last
);

    localparam int GW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic [GW-1:0] TERM = GW'(FRAME_LEN - 1);

    logic [GW-1:0] cnt_r;

    assign last = en && (cnt_r == TERM);

    // Group index: cleared on frame start, wraps after the final group.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= {GW{1'b0}};
        end else if (clr) begin
            cnt_r <= {GW{1'b0}};
        end else if (en) begin
            if (cnt_r == TERM) begin
                cnt_r <= {GW{1'b0}};
            end else begin
                cnt_r <= cnt_r + {{(GW-1){1'b0}}, 1'b1};
            end
        end else begin
            cnt_r <= cnt_r;
        end
    end

endmodule

// File: rtl/ones_count_accumulator.sv
// Sums FRAME_LEN 2-bit ones counts into a frame total with a one-cycle done pulse.
// Optional majority output enabled by ONES_MAJORITY_FLAG_EN.
module ones_count_accumulator
    import ones_count_pkg::*;
#(
    parameter int FRAME_LEN = DEFAULT_FRAME_LEN,
    localparam int CNT_W = cnt_width(FRAME_LEN)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    input  logic             y1,
    input  logic             y0,
    output logic             busy,
    output logic [CNT_W-1:0] count,
    output logic             done
`ifdef ONES_MAJORITY_FLAG_EN
    ,
    output logic             majority
`endif
);

    localparam logic [1:0] ST_IDLE  = 2'(IDLE);
    localparam logic [1:0] ST_ACCUM = 2'(ACCUM);
    localparam logic [1:0] ST_DONE  = 2'(DONE);

    logic [1:0]       state_r;
    logic [1:0]       state_nxt_s;
    logic [CNT_W-1:0] acc_r;
    logic [CNT_W-1:0] count_r;
    logic [CNT_W-1:0] grp_s;
    logic [CNT_W-1:0] sum_s;
    logic             done_r;
    logic             busy_r;
    logic             clr_s;
    logic             en_s;
    logic             last_s;

    assign grp_s = CNT_W'({y1, y0});
    assign sum_s = acc_r + grp_s;
    assign en_s  = (state_r == ST_ACCUM) && in_valid;
    // DONE accepts start exactly like IDLE so frames can run back to back.
    assign clr_s = ((state_r == ST_IDLE) || (state_r == ST_DONE)) && start;

    group_counter #(
        .FRAME_LEN(FRAME_LEN)
    ) u_group_counter (
        .clk (clk),
        .rst (rst),
        .clr (clr_s),
        .en  (en_s),
        .last(last_s)
    );

    // Next-state decode for the frame FSM.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE:  state_nxt_s = start ? ST_ACCUM : ST_IDLE;
            ST_ACCUM: state_nxt_s = last_s ? ST_DONE : ST_ACCUM;
            ST_DONE:  state_nxt_s = start ? ST_ACCUM : ST_IDLE;
            default:  state_nxt_s = ST_IDLE;
        endcase
    end

    // FSM state and registered busy/done flags derived from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            busy_r  <= (state_nxt_s == ST_ACCUM);
            done_r  <= (state_nxt_s == ST_DONE);
        end
    end

    // Running accumulator and the frame total, loaded only on the final group.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_r   <= {CNT_W{1'b0}};
            count_r <= {CNT_W{1'b0}};
        end else if (clr_s) begin
            acc_r   <= {CNT_W{1'b0}};
            count_r <= count_r;
        end else if (en_s) begin
            acc_r   <= sum_s;
            count_r <= last_s ? sum_s : count_r;
        end else begin
            acc_r   <= acc_r;
            count_r <= count_r;
        end
    end

`ifdef ONES_MAJORITY_FLAG_EN
    localparam logic [CNT_W-1:0] MAJ_THR = CNT_W'((3 * FRAME_LEN) / 2);

    logic majority_r;

    // Majority flag loaded alongside count.
    always_ff @(posedge clk) begin
        if (rst) begin
            majority_r <= 1'b0;
        end else if (en_s && last_s) begin
            majority_r <= (sum_s > MAJ_THR);
        end else begin
            majority_r <= majority_r;
        end
    end

    assign majority = majority_r;
`endif

    assign busy  = busy_r;
    assign done  = done_r;
    assign count = count_r;

endmodule

// File: tb/tb_ones_count_accumulator.sv
// Directed bench for ones_count_accumulator (FRAME_LEN=4) with a frame-total scoreboard.
module tb_ones_count_accumulator;

    localparam int FL    = 4;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             in_valid;
    logic             y1;
    logic             y0;
    logic             busy;
    logic [CNT_W-1:0] count;
    logic             done;
`ifdef ONES_MAJORITY_FLAG_EN
    logic             majority;
    logic             maj_q[$];
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int done_seen = 0;
    int acc_m = 0;
    int grp_m = 0;
    int exp_q[$];

    ones_count_accumulator #(
        .FRAME_LEN(FL)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .in_valid(in_valid),
        .y1      (y1),
        .y0      (y0),
        .busy    (busy),
        .count   (count),
        .done    (done)
`ifdef ONES_MAJORITY_FLAG_EN
        ,
        .majority(majority)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: frame totals are pushed when the final group is driven.
    task automatic model_start();
        acc_m = 0;
        grp_m = 0;
    endtask

    task automatic send(input int g);
        in_valid = 1'b1;
        {y1, y0} = 2'(g);
        acc_m += g;
        grp_m++;
        if (grp_m == FL) begin
            exp_q.push_back(acc_m);
`ifdef ONES_MAJORITY_FLAG_EN
            maj_q.push_back(acc_m > (3 * FL) / 2);
`endif
            grp_m = 0;
            acc_m = 0;
        end
        tick();
        in_valid = 1'b0;
        {y1, y0} = 2'b00;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        model_start();
        tick();
        start = 1'b0;
    endtask

    // Scoreboard: every done pulse must match the oldest expected frame total.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            done_seen++;
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 32'(done_seen), 32'(0));
            end else begin
                chk("frame_count", 32'(count), 32'(exp_q.pop_front()));
`ifdef ONES_MAJORITY_FLAG_EN
                chk("frame_majority", 32'(majority), 32'(maj_q.pop_front()));
`endif
            end
        end
    end

    initial begin
        rst = 1'b1; start = 1'b1; in_valid = 1'b1; y1 = 1'b1; y0 = 1'b1;
        // Reset dominates start and in_valid.
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("rst_busy", 32'(busy), 32'(0));
            chk("rst_done", 32'(done), 32'(0));
            chk("rst_count", 32'(count), 32'(0));
        end
        rst = 1'b0; start = 1'b0; in_valid = 1'b0; {y1, y0} = 2'b00;
        tick();

        // Full-scale frame 3,3,3,3.
        pulse_start();
        chk("t2_busy_on", 32'(busy), 32'(1));
        for (int i = 0; i < 3; i++) begin
            send(3);
            chk("t2_no_done", 32'(done), 32'(0));
        end
        send(3);
        chk("t2_done", 32'(done), 32'(1));
        chk("t2_count", 32'(count), 32'(12));
        chk("t2_busy_off", 32'(busy), 32'(0));
        tick();
        chk("t2_done_1cyc", 32'(done), 32'(0));

        // in_valid in IDLE is ignored.
        in_valid = 1'b1; {y1, y0} = 2'b11;
        tick(); tick();
        in_valid = 1'b0;
        chk("idle_busy", 32'(busy), 32'(0));
        chk("idle_count", 32'(count), 32'(12));

        // Gapped frame 1,-,-,2,0,3; start during ACCUM is ignored.
        pulse_start();
        send(1);
        start = 1'b1; tick(); start = 1'b0;
        chk("t3_gap_count", 32'(count), 32'(12));
        chk("t3_gap_busy", 32'(busy), 32'(1));
        tick();
        send(2);
        send(0);
        chk("t3_no_done", 32'(done), 32'(0));
        chk("t3_hold", 32'(count), 32'(12));
        send(3);
        chk("t3_done", 32'(done), 32'(1));
        chk("t3_count", 32'(count), 32'(6));
        tick();

        // Reset mid-frame discards the partial total.
        pulse_start();
        send(2);
        send(3);
        rst = 1'b1;
        model_start();
        tick();
        rst = 1'b0;
        chk("t4_count", 32'(count), 32'(0));
        chk("t4_busy", 32'(busy), 32'(0));
        chk("t4_done", 32'(done), 32'(0));
        tick();
        chk("t4_done2", 32'(done), 32'(0));
        pulse_start();
        for (int i = 0; i < FL; i++) send(1);
        chk("t4_count2", 32'(count), 32'(4));
        tick();

        // Back-to-back frames: start held in the DONE cycle.
        pulse_start();
        send(3); send(3); send(3); send(0);
        chk("t5_done", 32'(done), 32'(1));
        start = 1'b1;
        model_start();
        tick();
        start = 1'b0;
        chk("t5_busy_again", 32'(busy), 32'(1));
        chk("t5_done_off", 32'(done), 32'(0));
        chk("t5_hold", 32'(count), 32'(9));
        for (int i = 0; i < FL - 1; i++) send(0);
        chk("t5_hold2", 32'(count), 32'(9));
        send(0);
        chk("t5_done2", 32'(done), 32'(1));
        chk("t5_count2", 32'(count), 32'(0));
        tick();

`ifdef ONES_MAJORITY_FLAG_EN
        pulse_start();
        send(3); send(3); send(2); send(0);
        chk("t6_maj1", 32'(majority), 32'(1));
        tick();
        chk("t6_maj_hold", 32'(majority), 32'(1));
        pulse_start();
        send(1); send(1); send(2); send(2);
        chk("t6_maj0", 32'(majority), 32'(0));
        tick();
        chk("t6_done_total", 32'(done_seen), 32'(7));
`else
        chk("done_total", 32'(done_seen), 32'(5));
`endif
        chk("queue_empty", 32'(exp_q.size()), 32'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
